uart_frame_parser: RTL

- Receive-side framing stage directly downstream of uart_top. Drains the UART RX FIFO through rx_rd_en, rx_rd_data and rx_empty.
- Hunts for start-of-frame, then collects length, payload and checksum bytes.
- Buffers the payload internally and releases it on a valid/ready byte stream only after the checksum passes.
- Reports each frame result as a single-cycle ok or error pulse with an error code.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_frame_buf.sv | 26 ++
 rtl/uart_frame_parser.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive framing path.
package uart_pkg;

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, EMIT} state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: one synchronous write port, one combinational read port.
module uart_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MAX_LEN];

    // NOTE: storage arrays carry no reset; every entry is written before it is read.
    // NOTE: clocked state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Receive framing stage: drains the RX FIFO, validates SOF/LEN/payload/CHK frames
// and streams the payload out only after the checksum has passed.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       rx_rd_en,
    input  logic [7:0] rx_rd_data,
    input  logic       rx_empty,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_last,
    input  logic       m_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    state_t          state, state_nx;
    logic            rd_pend, rd_pend_nx;
    logic [LW-1:0]   len, len_nx;
    logic [LW-1:0]   idx, idx_nx;
    logic [LW-1:0]   rd_idx, rd_idx_nx;
    logic [7:0]      chk, chk_nx;
    logic [TW-1:0]   tmo_cnt, tmo_nx;
    logic [1:0]      err_code_q, err_code_nx;
    logic            capture, in_frame, tmo_fire, buf_we;
    logic [7:0]      buf_rdata;

    // The byte requested last cycle is on rx_rd_data now.
    assign capture  = rd_pend;
    assign in_frame = state inside {LEN, PAYLOAD, CHK};
    assign tmo_fire = in_frame && !capture && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign buf_we   = (state == PAYLOAD) && capture;
    assign busy     = (state != HUNT);
    // The reason is visible during the pulse itself and held afterwards.
    assign err_code = frame_err ? err_code_nx : err_code_q;

    uart_frame_buf #(.MAX_LEN(MAX_LEN), .AW(IW)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx[IW-1:0]),
        .wdata (rx_rd_data),
        .raddr (rd_idx[IW-1:0]),
        .rdata (buf_rdata)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nx    = state;
        rd_pend_nx  = rd_pend;
        len_nx      = len;
        idx_nx      = idx;
        rd_idx_nx   = rd_idx;
        chk_nx      = chk;
        err_code_nx = err_code_q;
        tmo_nx      = in_frame ? tmo_cnt + TW'(1) : '0;
        rx_rd_en    = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_last      = 1'b0;
        frame_ok    = 1'b0;
        frame_err   = 1'b0;

        if (capture) begin
            rd_pend_nx = 1'b0;
            tmo_nx     = '0;
        end
        if (rst && state != EMIT && !rd_pend && !rx_empty && !tmo_fire) begin
            rx_rd_en   = 1'b1;
            rd_pend_nx = 1'b1;
        end

        case (state)
            HUNT: begin
                if (capture && rx_rd_data == SOF_BYTE) state_nx = LEN;
            end
            LEN: begin
                if (capture) begin
                    if (rx_rd_data == 8'd0 || rx_rd_data > 8'(MAX_LEN)) begin
                        frame_err   = 1'b1;
                        err_code_nx = ERR_LEN;
                        state_nx    = HUNT;
                    end else begin
                        len_nx   = rx_rd_data[LW-1:0];
                        chk_nx   = rx_rd_data;
                        idx_nx   = '0;
                        state_nx = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (capture) begin
                    chk_nx = chk ^ rx_rd_data;
                    idx_nx = idx + LW'(1);
                    if (idx + LW'(1) == len) state_nx = CHK;
                end
            end
            CHK: begin
                if (capture) begin
                    if (rx_rd_data == chk) begin
                        rd_idx_nx = '0;
                        state_nx  = EMIT;
                    end else begin
                        frame_err   = 1'b1;
                        err_code_nx = ERR_CHK;
                        state_nx    = HUNT;
                    end
                end
            end
            EMIT: begin
                m_valid = 1'b1;
                m_data  = buf_rdata;
                m_last  = (rd_idx == len - LW'(1));
                if (m_ready) begin
                    rd_idx_nx = rd_idx + LW'(1);
                    if (m_last) begin
                        frame_ok = 1'b1;
                        state_nx = HUNT;
                    end
                end
            end
            default: state_nx = HUNT;
        endcase

        if (tmo_fire) begin
            frame_err   = 1'b1;
            err_code_nx = ERR_TMO;
            state_nx    = HUNT;
            rd_pend_nx  = 1'b0;
            tmo_nx      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            rd_pend    <= 1'b0;
            len        <= '0;
            idx        <= '0;
            rd_idx     <= '0;
            chk        <= '0;
            tmo_cnt    <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state      <= state_nx;
            rd_pend    <= rd_pend_nx;
            len        <= len_nx;
            idx        <= idx_nx;
            rd_idx     <= rd_idx_nx;
            chk        <= chk_nx;
            tmo_cnt    <= tmo_nx;
            err_code_q <= err_code_nx;
        end
    end

endmodule
